// File: rtl/dcache_sdpram_clr.sv
// ---------------------------------------------------------------------------
// dcache_sdpram_clr
//
// Single-clock simple-dual-port RAM for D-cache data/tag arrays. Per-lane
// byte enables on the write port, a clear engine that zeroes every entry
// after reset (optional) or on request, write-first forwarding when a read
// and a write hit the same address on the same edge, and an optional output
// register stage.
//
// Ports:
//   i_clk         clock for all logic and the array
//   i_rst_n       asynchronous active-low reset (array contents untouched)
//   i_wr_en       write request (ignored while o_init_done=0)
//   i_wr_addr     write address
//   i_wr_data     write data
//   i_wr_byte_en  per-lane write enable, lane i = [i*BYTE_SIZE +: BYTE_SIZE]
//   i_rd_en       read request (ignored while o_init_done=0)
//   i_rd_addr     read address
//   o_rd_data     read data; holds the last valid word between strobes
//   o_rd_valid    one-cycle strobe marking o_rd_data valid
//   i_clear_req   single-cycle pulse starting a full-array clear
//   o_init_done   high when the array accepts user reads/writes
// ---------------------------------------------------------------------------
module dcache_sdpram_clr #(
  parameter  int ADDR_WIDTH     = 9,
  parameter  int DATA_WIDTH     = 32,
  parameter  int BYTE_SIZE      = 8,
  parameter  int OUTPUT_REG     = 0,
  parameter  int CLEAR_ON_RESET = 1,
  localparam int BE_WIDTH       = DATA_WIDTH / BYTE_SIZE
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic [BE_WIDTH-1:0]   i_wr_byte_en,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_valid,
  input  logic                  i_clear_req,
  output logic                  o_init_done
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  if (DATA_WIDTH % BYTE_SIZE != 0) begin : g_bad_width
    $error("dcache_sdpram_clr: DATA_WIDTH must be a multiple of BYTE_SIZE");
  end

  typedef enum logic {ST_CLEAR, ST_READY} state_t;
  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_clr_addr;
  logic                    r_init_done;

  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
  logic [DATA_WIDTH-1:0]   r_mem_q;
  logic                    r_s1_valid;
  logic                    r_have_data;
  logic [BE_WIDTH-1:0]     r_fwd_mask;
  logic [DATA_WIDTH-1:0]   r_fwd_data;

  logic                    w_clr_active;
  logic                    w_wr_acc;
  logic                    w_rd_acc;
  logic                    w_collide;
  logic [ADDR_WIDTH-1:0]   w_mem_addr;
  logic [DATA_WIDTH-1:0]   w_mem_data;
  logic [BE_WIDTH-1:0]     w_mem_be;
  logic [DATA_WIDTH-1:0]   w_s1_word;
  logic [DATA_WIDTH-1:0]   w_s1_out;

  // Clear engine. o_init_done is exactly "state is READY", registered.
  // A clear_req while clearing is ignored, so a clear is always DEPTH cycles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= RESET_STATE;
      r_clr_addr  <= '0;
      r_init_done <= (CLEAR_ON_RESET == 0);
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_clr_addr <= r_clr_addr + 1'b1;
          if (r_clr_addr == LAST_ADDR) begin
            r_state     <= ST_READY;
            r_init_done <= 1'b1;
          end
        end
        ST_READY: begin
          if (i_clear_req) begin
            r_state     <= ST_CLEAR;
            r_clr_addr  <= '0;
            r_init_done <= 1'b0;
          end
        end
        default: r_state <= RESET_STATE;
      endcase
    end
  end

  // Clear writes are gated by i_rst_n so a held reset never zeroes entry 0.
  assign w_clr_active = (r_state == ST_CLEAR) && i_rst_n;
  assign w_wr_acc     = i_wr_en && r_init_done;
  assign w_rd_acc     = i_rd_en && r_init_done;
  assign w_collide    = w_rd_acc && w_wr_acc && (i_rd_addr == i_wr_addr);

  // The write port is shared between the clear engine and the user; the two
  // are mutually exclusive because user access needs o_init_done.
  assign w_mem_addr = w_clr_active ? r_clr_addr : i_wr_addr;
  assign w_mem_data = w_clr_active ? '0 : i_wr_data;
  assign w_mem_be   = w_clr_active ? '1 : (w_wr_acc ? i_wr_byte_en : '0);

  // Block-RAM style array: registered read returns the old word on a
  // same-address collision; forwarding below patches in the new lanes.
  always_ff @(posedge i_clk) begin
    if (w_rd_acc) begin
      r_mem_q <= r_mem[i_rd_addr];
    end
    for (int b = 0; b < BE_WIDTH; b++) begin
      if (w_mem_be[b]) begin
        r_mem[w_mem_addr][b*BYTE_SIZE +: BYTE_SIZE] <= w_mem_data[b*BYTE_SIZE +: BYTE_SIZE];
      end
    end
  end

  // Stage-1 control: read strobe, collision lane mask and write data.
  // r_have_data keeps the output at zero after reset until a read lands.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_valid  <= 1'b0;
      r_have_data <= 1'b0;
      r_fwd_mask  <= '0;
      r_fwd_data  <= '0;
    end else begin
      r_s1_valid <= w_rd_acc;
      if (w_rd_acc) begin
        r_have_data <= 1'b1;
        r_fwd_mask  <= w_collide ? i_wr_byte_en : '0;
        r_fwd_data  <= i_wr_data;
      end
    end
  end

  // Write-first merge per lane for collided reads.
  always_comb begin
    w_s1_word = r_mem_q;
    for (int b = 0; b < BE_WIDTH; b++) begin
      if (r_fwd_mask[b]) begin
        w_s1_word[b*BYTE_SIZE +: BYTE_SIZE] = r_fwd_data[b*BYTE_SIZE +: BYTE_SIZE];
      end
    end
  end

  assign w_s1_out = r_have_data ? w_s1_word : '0;

  if (OUTPUT_REG != 0) begin : g_oreg
    logic                  r_s2_valid;
    logic [DATA_WIDTH-1:0] r_rd_data;

    // Extra pipeline stage; in-flight reads finish even if a clear starts.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_s2_valid <= 1'b0;
        r_rd_data  <= '0;
      end else begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_rd_data <= w_s1_out;
        end
      end
    end

    assign o_rd_valid = r_s2_valid;
    assign o_rd_data  = r_rd_data;
  end else begin : g_nooreg
    assign o_rd_valid = r_s1_valid;
    assign o_rd_data  = w_s1_out;
  end

  assign o_init_done = r_init_done;

endmodule

// File: tb/tb_dcache_sdpram_clr.sv
// ---------------------------------------------------------------------------
// tb_dcache_sdpram_clr
//
// Drives three instances from the same stimulus: dut0 (no output register),
// dut1 (output register, so its results trail dut0 by one cycle) and dut2
// (no clear on reset, only its init_done is checked). Expected values are
// hand-computed in the vector table and the corner-case sequences.
// ---------------------------------------------------------------------------
module tb_dcache_sdpram_clr;

  logic        clk = 1'b0;
  logic        rstN = 1'b1;
  logic        wrEn = 1'b0;
  logic [8:0]  wrAddr = '0;
  logic [31:0] wrData = '0;
  logic [3:0]  wrBe = '0;
  logic        rdEn = 1'b0;
  logic [8:0]  rdAddr = '0;
  logic        clearReq = 1'b0;

  logic [31:0] d0RdData, d1RdData, d2RdData;
  logic        d0RdValid, d1RdValid, d2RdValid;
  logic        d0InitDone, d1InitDone, d2InitDone;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        wrEn;
    logic [8:0]  wrAddr;
    logic [31:0] wrData;
    logic [3:0]  wrBe;
    logic        rdEn;
    logic [8:0]  rdAddr;
    logic        expValid;
    logic [31:0] expData;
  } vec_t;

  vec_t vecs [17];

  dcache_sdpram_clr #(.OUTPUT_REG(0), .CLEAR_ON_RESET(1)) dut0 (
    .i_clk(clk), .i_rst_n(rstN), .i_wr_en(wrEn), .i_wr_addr(wrAddr),
    .i_wr_data(wrData), .i_wr_byte_en(wrBe), .i_rd_en(rdEn), .i_rd_addr(rdAddr),
    .o_rd_data(d0RdData), .o_rd_valid(d0RdValid), .i_clear_req(clearReq),
    .o_init_done(d0InitDone)
  );

  dcache_sdpram_clr #(.OUTPUT_REG(1), .CLEAR_ON_RESET(1)) dut1 (
    .i_clk(clk), .i_rst_n(rstN), .i_wr_en(wrEn), .i_wr_addr(wrAddr),
    .i_wr_data(wrData), .i_wr_byte_en(wrBe), .i_rd_en(rdEn), .i_rd_addr(rdAddr),
    .o_rd_data(d1RdData), .o_rd_valid(d1RdValid), .i_clear_req(clearReq),
    .o_init_done(d1InitDone)
  );

  dcache_sdpram_clr #(.OUTPUT_REG(0), .CLEAR_ON_RESET(0)) dut2 (
    .i_clk(clk), .i_rst_n(rstN), .i_wr_en(wrEn), .i_wr_addr(wrAddr),
    .i_wr_data(wrData), .i_wr_byte_en(wrBe), .i_rd_en(rdEn), .i_rd_addr(rdAddr),
    .o_rd_data(d2RdData), .o_rd_valid(d2RdValid), .i_clear_req(clearReq),
    .o_init_done(d2InitDone)
  );

  // 10-time-unit clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Hard stop in case something wedges the stimulus thread.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    wrEn   = v.wrEn;
    wrAddr = v.wrAddr;
    wrData = v.wrData;
    wrBe   = v.wrBe;
    rdEn   = v.rdEn;
    rdAddr = v.rdAddr;
  endtask

  task automatic idleInputs();
    wrEn = 1'b0; wrBe = '0; rdEn = 1'b0; clearReq = 1'b0;
  endtask

  task automatic writeWord(input logic [8:0] addr, input logic [31:0] data);
    wrEn = 1'b1; wrAddr = addr; wrData = data; wrBe = 4'hF;
    tick();
    wrEn = 1'b0; wrBe = '0;
  endtask

  // Single read; dut0 answers after the accepting edge, dut1 one edge later.
  task automatic doRead(input string name, input logic [8:0] addr,
                        input logic [31:0] exp);
    rdEn = 1'b1; rdAddr = addr;
    tick();
    rdEn = 1'b0;
    checkOutput({name, "_d0valid"}, 32'(d0RdValid), 32'd1);
    checkOutput({name, "_d0data"}, d0RdData, exp);
    checkOutput({name, "_d1early"}, 32'(d1RdValid), 32'd0);
    tick();
    checkOutput({name, "_d1valid"}, 32'(d1RdValid), 32'd1);
    checkOutput({name, "_d1data"}, d1RdData, exp);
    checkOutput({name, "_d0drop"}, 32'(d0RdValid), 32'd0);
    checkOutput({name, "_d0hold"}, d0RdData, exp);
    tick();
  endtask

  // Count edges until dut0 reports ready, bounded.
  task automatic waitInit(output int cnt);
    cnt = 0;
    while (!d0InitDone && cnt < 600) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    int cnt;
    logic        prevValid;
    logic [31:0] prevData;

    vecs[0]  = '{1'b1, 9'h010, 32'hAABBCCDD, 4'hF, 1'b0, 9'h000, 1'b0, 32'h00000000};
    vecs[1]  = '{1'b1, 9'h010, 32'h11223344, 4'h5, 1'b0, 9'h000, 1'b0, 32'h00000000};
    vecs[2]  = '{1'b0, 9'h000, 32'h00000000, 4'h0, 1'b1, 9'h010, 1'b1, 32'hAA22CC44};
    vecs[3]  = '{1'b1, 9'h020, 32'h12345678, 4'hF, 1'b0, 9'h000, 1'b0, 32'hAA22CC44};
    vecs[4]  = '{1'b1, 9'h020, 32'hFFFFFFFF, 4'h8, 1'b1, 9'h020, 1'b1, 32'hFF345678};
    vecs[5]  = '{1'b0, 9'h000, 32'h00000000, 4'h0, 1'b1, 9'h020, 1'b1, 32'hFF345678};
    vecs[6]  = '{1'b1, 9'h030, 32'hCAFEF00D, 4'hF, 1'b1, 9'h031, 1'b1, 32'h00000000};
    vecs[7]  = '{1'b1, 9'h031, 32'h01020304, 4'h0, 1'b1, 9'h030, 1'b1, 32'hCAFEF00D};
    vecs[8]  = '{1'b0, 9'h000, 32'h00000000, 4'h0, 1'b1, 9'h031, 1'b1, 32'h00000000};
    vecs[9]  = '{1'b1, 9'h001, 32'h00000111, 4'hF, 1'b0, 9'h000, 1'b0, 32'h00000000};
    vecs[10] = '{1'b1, 9'h002, 32'h00000222, 4'hF, 1'b0, 9'h000, 1'b0, 32'h00000000};
    vecs[11] = '{1'b1, 9'h003, 32'h00000333, 4'hF, 1'b0, 9'h000, 1'b0, 32'h00000000};
    vecs[12] = '{1'b0, 9'h000, 32'h00000000, 4'h0, 1'b1, 9'h001, 1'b1, 32'h00000111};
    vecs[13] = '{1'b0, 9'h000, 32'h00000000, 4'h0, 1'b1, 9'h002, 1'b1, 32'h00000222};
    vecs[14] = '{1'b0, 9'h000, 32'h00000000, 4'h0, 1'b1, 9'h003, 1'b1, 32'h00000333};
    vecs[15] = '{1'b0, 9'h000, 32'h00000000, 4'h0, 1'b0, 9'h000, 1'b0, 32'h00000333};
    vecs[16] = '{1'b0, 9'h000, 32'h00000000, 4'h0, 1'b0, 9'h000, 1'b0, 32'h00000333};

    // Power-on reset and defaults.
    #2 rstN = 1'b0;
    tick(); tick();
    checkOutput("rst_d0data", d0RdData, 32'h0);
    checkOutput("rst_d0valid", 32'(d0RdValid), 32'd0);
    checkOutput("rst_d0init", 32'(d0InitDone), 32'd0);
    checkOutput("rst_d1data", d1RdData, 32'h0);
    checkOutput("rst_d2init", 32'(d2InitDone), 32'd1);
    rstN = 1'b1;
    waitInit(cnt);
    checkOutput("init_cycles", 32'(cnt), 32'd512);
    checkOutput("init_d1", 32'(d1InitDone), 32'd1);
    checkOutput("init_d2", 32'(d2InitDone), 32'd1);
    doRead("rd1ff", 9'h1FF, 32'h0);

    // Table-driven: byte enables, collision, forwarding, pipelined reads.
    prevValid = 1'b0;
    prevData  = 32'h0;
    for (int k = 0; k < 17; k++) begin
      applyStimulus(vecs[k]);
      tick();
      checkOutput($sformatf("vec%0d_d0valid", k), 32'(d0RdValid), 32'(vecs[k].expValid));
      checkOutput($sformatf("vec%0d_d0data", k), d0RdData, vecs[k].expData);
      checkOutput($sformatf("vec%0d_d1valid", k), 32'(d1RdValid), 32'(prevValid));
      checkOutput($sformatf("vec%0d_d1data", k), d1RdData, prevData);
      prevValid = vecs[k].expValid;
      prevData  = vecs[k].expData;
    end
    idleInputs();
    tick();

    // Requested clear: a read on the clear_req edge still returns old data,
    // user access during the clear is ignored, and a second request does not
    // extend the clear.
    writeWord(9'h0AB, 32'hDEADBEEF);
    clearReq = 1'b1; rdEn = 1'b1; rdAddr = 9'h0AB;
    tick();
    idleInputs();
    checkOutput("clr_initfall", 32'(d0InitDone), 32'd0);
    checkOutput("clr_prerd_d0", d0RdData, 32'hDEADBEEF);
    checkOutput("clr_prerd_d0v", 32'(d0RdValid), 32'd1);
    cnt = 0;
    while (!d0InitDone && cnt < 600) begin
      if (cnt == 5) begin rdEn = 1'b1; rdAddr = 9'h0AB; end
      if (cnt == 6) rdEn = 1'b0;
      if (cnt == 99) clearReq = 1'b1;
      if (cnt == 100) clearReq = 1'b0;
      if (cnt == 300) begin
        wrEn = 1'b1; wrAddr = 9'h0AB; wrData = 32'h12345678; wrBe = 4'hF;
      end
      if (cnt == 301) begin wrEn = 1'b0; wrBe = '0; end
      tick();
      cnt++;
      if (cnt == 1) begin
        checkOutput("clr_inflight_d1v", 32'(d1RdValid), 32'd1);
        checkOutput("clr_inflight_d1", d1RdData, 32'hDEADBEEF);
      end
      if (cnt == 6) begin
        checkOutput("clr_rdign_v", 32'(d0RdValid), 32'd0);
        checkOutput("clr_rdign_hold", d0RdData, 32'hDEADBEEF);
      end
    end
    idleInputs();
    checkOutput("clr_cycles", 32'(cnt), 32'd512);
    doRead("clr_rd0ab", 9'h0AB, 32'h0);
    doRead("clr_rd010", 9'h010, 32'h0);

    // Reset in the middle of a clear.
    writeWord(9'h1F0, 32'h0F0F0F0F);
    doRead("pre_rst_rd", 9'h1F0, 32'h0F0F0F0F);
    clearReq = 1'b1;
    tick();
    clearReq = 1'b0;
    repeat (100) tick();
    rstN = 1'b0;
    #1;
    checkOutput("mid_rst_d0data", d0RdData, 32'h0);
    checkOutput("mid_rst_d1data", d1RdData, 32'h0);
    checkOutput("mid_rst_d0valid", 32'(d0RdValid), 32'd0);
    checkOutput("mid_rst_d2init", 32'(d2InitDone), 32'd1);
    tick(); tick(); tick();
    rstN = 1'b1;
    waitInit(cnt);
    checkOutput("rerst_cycles", 32'(cnt), 32'd512);
    doRead("rerst_rd1f0", 9'h1F0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_sdpram_clr.md
Name: dcache_sdpram_clr

Overview:
- Parametrised single-clock simple-dual-port cache data/tag RAM with per-byte write enables. Successor to the fixed 512x32 cache SRAM instances.
- Adds three things: a built-in clear engine that zeroes the whole array after reset or on request (cache invalidate), write-to-read forwarding on same-address collisions, and an optional output register with a read-valid strobe.
- Sits between the D-cache controller and the inferred block RAM. One instance per way/array.

Parameters:
- ADDR_WIDTH, 9, address bits; DEPTH = 2^ADDR_WIDTH entries.
- DATA_WIDTH, 32, word width; must be an integer multiple of BYTE_SIZE.
- BYTE_SIZE, 8, bits per byte lane (8 or 9); BE_WIDTH = DATA_WIDTH/BYTE_SIZE is derived.
- OUTPUT_REG, 0, 1 adds one output pipeline stage (read latency 2 instead of 1).
- CLEAR_ON_RESET, 1, 1 runs the clear engine automatically after reset release.

Ports:
- clk, input, 1, single clock for all logic and the array.
- rst_n, input, 1, asynchronous active-low reset.
- wr_en, input, 1, write request.
- wr_addr, input, ADDR_WIDTH, write address.
- wr_data, input, DATA_WIDTH, write data.
- wr_byte_en, input, BE_WIDTH, per-lane write enable; lane i covers bits [i*BYTE_SIZE +: BYTE_SIZE].
- rd_en, input, 1, read request.
- rd_addr, input, ADDR_WIDTH, read address.
- rd_data, output, DATA_WIDTH, read data.
- rd_valid, output, 1, one-cycle strobe marking rd_data valid.
- clear_req, input, 1, single-cycle pulse that starts a full-array clear.
- init_done, output, 1, high when the array is ready for user access.

Behaviour:
- Reset values: rd_data=0, rd_valid=0, output-register stage=0, clr_addr=0. init_done=0 if CLEAR_ON_RESET=1, else 1. Array contents are not touched by rst_n.
- FSM states: CLEAR and READY.
  - Reset enters CLEAR if CLEAR_ON_RESET=1, otherwise READY.
  - CLEAR: each cycle writes all-zero to mem[clr_addr], all lanes enabled, then clr_addr increments. On clr_addr==DEPTH-1, go to READY and set init_done=1 on the next edge. A clear takes exactly DEPTH cycles.
  - READY: clear_req=1 goes to CLEAR; clr_addr=0 and init_done=0 on the next edge.
  - clear_req while in CLEAR is ignored; it neither restarts nor extends the clear.
- Asserting rst_n low mid-clear aborts the clear. Release restarts it from address 0, per CLEAR_ON_RESET.
- While init_done=0, wr_en and rd_en are ignored: no array write, rd_valid stays 0, rd_data holds its value.
- Write, READY only: on a clk edge with wr_en=1, mem[wr_addr] lane i is updated only where wr_byte_en[i]=1. wr_byte_en=0 means no change.
- Read latency:
  - OUTPUT_REG=0: rd_en accepted at edge N gives rd_data and rd_valid=1 after edge N+1, valid for one cycle.
  - OUTPUT_REG=1: same, one cycle later (after edge N+2).
  - Fully pipelined: back-to-back reads give one result per cycle.
- rd_valid=0 cycles: rd_data holds the last valid value and is never zeroed.
- Same-cycle collision (rd_en & wr_en & rd_addr==wr_addr): returned word is write-first per lane, i.e. wr_byte_en[i] ? wr_data lane : old mem lane. Different addresses do not interact.
- A write at edge N is visible to a read issued at edge N+1 or later.
- A read accepted on the same edge that clear_req is taken completes normally with pre-clear data.
- Pipeline stages already in flight when CLEAR starts still deliver their rd_valid.
- Address arithmetic wraps modulo DEPTH. No out-of-range addresses exist.
- Elaboration error if DATA_WIDTH % BYTE_SIZE != 0.

Test Plan:
- Reset release, defaults: init_done low for exactly 512 cycles, then high. Read of addr 0x1FF returns 0x00000000 with rd_valid one cycle after rd_en.
- Byte enables: write 0xAABBCCDD to 0x010 with be=4'b1111, then 0x11223344 with be=4'b0101. Read 0x010 returns 0xAA22CC44.
- Collision: mem[0x020]=0x12345678. Same cycle, write 0xFFFFFFFF be=4'b1000 and read 0x020. Returns 0xFF345678; a read next cycle also returns 0xFF345678.
- OUTPUT_REG=1: reads of 0x001, 0x002, 0x003 on consecutive cycles return the three words in order on cycles N+2..N+4, with rd_valid high for 3 consecutive cycles.
- clear_req in READY after writing 0xDEADBEEF to 0x0AB: init_done falls next cycle. User write during clear is ignored. After 512 cycles a read of 0x0AB returns 0. A second clear_req pulse mid-clear does not lengthen the clear.
- Reset mid-operation: rst_n low at cycle 100 of a clear. rd_valid and rd_data go to 0 immediately. After release, init_done stays low a full 512 cycles.
